// File: rtl/exec_unit_iqueue_pkg.sv
// Types shared by the exec-unit issue queue and the interconnect.
// The entry layout is what the ALU sees on its current-instruction input.
package exec_unit_dtypes;

    localparam int IQUEUE_DEPTH    = 4;
    localparam int IQ_TAG_WIDTH    = 4;
    localparam int IQ_OPCODE_WIDTH = 4;

    typedef struct packed {
        logic [IQ_OPCODE_WIDTH-1:0] opcode;
        logic [IQ_TAG_WIDTH-1:0]    dest_tag;
        logic [IQ_TAG_WIDTH-1:0]    src_a_tag;
        logic                       src_a_rdy;
        logic [IQ_TAG_WIDTH-1:0]    src_b_tag;
        logic                       src_b_rdy;
    } type_iqueue_entry;

endpackage

// File: rtl/exec_unit_iqueue_if.sv
// Dispatch, wakeup and issue signals of the issue queue.
// The queue uses the slave view; dispatch/ALU/interconnect use master.
interface exec_unit_iqueue_if
    import exec_unit_dtypes::*;
#(
    parameter int DEPTH = IQUEUE_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                    flush_i;
    logic                    disp_valid_i;
    logic                    disp_ready_o;
    type_iqueue_entry        disp_instr_i;
    logic                    wake_valid_i;
    logic [IQ_TAG_WIDTH-1:0] wake_tag_i;
    logic                    issue_valid_o;
    logic                    issue_ready_i;
    type_iqueue_entry        issue_instr_o;
    logic [CW-1:0]           count_o;

    modport slave (
        input  flush_i, disp_valid_i, disp_instr_i,
        input  wake_valid_i, wake_tag_i, issue_ready_i,
        output disp_ready_o, issue_valid_o, issue_instr_o, count_o
    );

    modport master (
        output flush_i, disp_valid_i, disp_instr_i,
        output wake_valid_i, wake_tag_i, issue_ready_i,
        input  disp_ready_o, issue_valid_o, issue_instr_o, count_o
    );

endinterface

// File: rtl/exec_unit_iqueue_wakeup_match.sv
// Tag comparator for one queue slot: raises a source ready flag
// when the broadcast tag matches; flags never fall here.
module iqueue_wakeup_match
    import exec_unit_dtypes::*;
(
    input  logic [IQ_TAG_WIDTH-1:0] src_a_tag_i,
    input  logic                    src_a_rdy_i,
    input  logic [IQ_TAG_WIDTH-1:0] src_b_tag_i,
    input  logic                    src_b_rdy_i,
    input  logic                    wake_valid_i,
    input  logic [IQ_TAG_WIDTH-1:0] wake_tag_i,
    output logic                    src_a_rdy_o,
    output logic                    src_b_rdy_o
);

    always_comb begin
        src_a_rdy_o = src_a_rdy_i | (wake_valid_i & (wake_tag_i == src_a_tag_i));
        src_b_rdy_o = src_b_rdy_i | (wake_valid_i & (wake_tag_i == src_b_tag_i));
    end

endmodule

// File: rtl/exec_unit_iqueue.sv
// In-order issue queue feeding the ALU/cache stage. Entries wait here
// until both source tags have been broadcast, then issue from the head.
module exec_unit_iqueue
    import exec_unit_dtypes::*;
#(
    parameter int DEPTH = IQUEUE_DEPTH
)(
    input  logic               clk,
    input  logic               reset,
    exec_unit_iqueue_if.slave  io
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    type_iqueue_entry entries_q [DEPTH];
    type_iqueue_entry entries_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] wake_a_rdy, wake_b_rdy;
    logic             byp_a_rdy, byp_b_rdy;
    type_iqueue_entry disp_entry;
    type_iqueue_entry head_entry;
    logic             disp_fire, issue_fire;

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        iqueue_wakeup_match u_match (
            .src_a_tag_i  (entries_q[i].src_a_tag),
            .src_a_rdy_i  (entries_q[i].src_a_rdy),
            .src_b_tag_i  (entries_q[i].src_b_tag),
            .src_b_rdy_i  (entries_q[i].src_b_rdy),
            .wake_valid_i (io.wake_valid_i),
            .wake_tag_i   (io.wake_tag_i),
            .src_a_rdy_o  (wake_a_rdy[i]),
            .src_b_rdy_o  (wake_b_rdy[i])
        );
    end

    // Catch a broadcast landing in the same cycle as the dispatch write
    iqueue_wakeup_match u_byp_match (
        .src_a_tag_i  (io.disp_instr_i.src_a_tag),
        .src_a_rdy_i  (io.disp_instr_i.src_a_rdy),
        .src_b_tag_i  (io.disp_instr_i.src_b_tag),
        .src_b_rdy_i  (io.disp_instr_i.src_b_rdy),
        .wake_valid_i (io.wake_valid_i),
        .wake_tag_i   (io.wake_tag_i),
        .src_a_rdy_o  (byp_a_rdy),
        .src_b_rdy_o  (byp_b_rdy)
    );

    always_comb begin
        disp_entry           = io.disp_instr_i;
        disp_entry.src_a_rdy = byp_a_rdy;
        disp_entry.src_b_rdy = byp_b_rdy;
    end

    assign head_entry       = entries_q[head_q];
    assign io.disp_ready_o  = !reset && (count_q < CW'(DEPTH));
    assign io.issue_valid_o = (count_q != '0) && head_entry.src_a_rdy
                              && head_entry.src_b_rdy;
    assign io.issue_instr_o = head_entry;
    assign io.count_o       = count_q;

    assign disp_fire  = io.disp_valid_i & io.disp_ready_o;
    assign issue_fire = io.issue_valid_o & io.issue_ready_i;

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                entries_d[i].src_a_rdy = wake_a_rdy[i];
                entries_d[i].src_b_rdy = wake_b_rdy[i];
            end
        end

        if (issue_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end

        if (disp_fire) begin
            entries_d[tail_q] = disp_entry;
            valid_d[tail_q]   = 1'b1;
            tail_d            = tail_q + PW'(1);
        end

        unique case ({disp_fire, issue_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flush drops everything, including whatever fired this cycle
        if (io.flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_exec_unit_iqueue.sv
// Directed and random stimulus for exec_unit_iqueue, checked against
// a queue-based reference model of in-order issue with tag wakeup.
module tb_exec_unit_iqueue;
    import exec_unit_dtypes::*;

    localparam int DEPTH = IQUEUE_DEPTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    exec_unit_iqueue_if #(.DEPTH(DEPTH)) io ();

    exec_unit_iqueue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    type_iqueue_entry mq[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic type_iqueue_entry mk(int op, int dst, int a,
                                            int ar, int b, int br);
        type_iqueue_entry e;
        e.opcode    = op[IQ_OPCODE_WIDTH-1:0];
        e.dest_tag  = dst[IQ_TAG_WIDTH-1:0];
        e.src_a_tag = a[IQ_TAG_WIDTH-1:0];
        e.src_a_rdy = ar[0];
        e.src_b_tag = b[IQ_TAG_WIDTH-1:0];
        e.src_b_rdy = br[0];
        return e;
    endfunction

    task automatic idle();
        reset           = 1'b0;
        io.flush_i      = 1'b0;
        io.disp_valid_i = 1'b0;
        io.disp_instr_i = '0;
        io.wake_valid_i = 1'b0;
        io.wake_tag_i   = '0;
    endtask

    task automatic disp(type_iqueue_entry e);
        io.disp_valid_i = 1'b1;
        io.disp_instr_i = e;
    endtask

    // Check outputs against the model, then advance one clock.
    task automatic cyc();
        bit exp_dr, exp_iv, dfire, ifire;
        type_iqueue_entry e;
        #1;
        exp_dr = !reset && (mq.size() < DEPTH);
        exp_iv = (mq.size() != 0) && mq[0].src_a_rdy && mq[0].src_b_rdy;
        chk("disp_ready", 32'(io.disp_ready_o), 32'(exp_dr));
        chk("issue_valid", 32'(io.issue_valid_o), 32'(exp_iv));
        chk("count", 32'(io.count_o), mq.size());
        if (exp_iv)
            chk("issue_instr", 32'(io.issue_instr_o), 32'(mq[0]));
        dfire = io.disp_valid_i && exp_dr;
        ifire = exp_iv && io.issue_ready_i;
        @(posedge clk);
        if (reset || io.flush_i) begin
            mq.delete();
        end else begin
            if (io.wake_valid_i) begin
                foreach (mq[i]) begin
                    if (mq[i].src_a_tag == io.wake_tag_i) mq[i].src_a_rdy = 1'b1;
                    if (mq[i].src_b_tag == io.wake_tag_i) mq[i].src_b_rdy = 1'b1;
                end
            end
            if (ifire) void'(mq.pop_front());
            if (dfire) begin
                e = io.disp_instr_i;
                if (io.wake_valid_i && e.src_a_tag == io.wake_tag_i) e.src_a_rdy = 1'b1;
                if (io.wake_valid_i && e.src_b_tag == io.wake_tag_i) e.src_b_rdy = 1'b1;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset            = 1'b1;
        io.issue_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_instr", 32'(io.issue_instr_o), 32'h0);
        chk("reset_count", 32'(io.count_o), 32'h0);
        cyc();

        // single ready entry: issue one cycle after dispatch
        idle();
        io.issue_ready_i = 1'b1;
        disp(mk(3, 0, 1, 1, 2, 1));
        cyc();
        idle();
        #1;
        chk("t1_opcode", 32'(io.issue_instr_o.opcode), 32'h3);
        chk("t1_count", 32'(io.count_o), 32'h1);
        cyc();
        cyc();

        // src_b waits for tag 5
        disp(mk(4, 1, 3, 1, 5, 0));
        cyc();
        idle();
        cyc();
        cyc();
        io.wake_valid_i = 1'b1;
        io.wake_tag_i   = 4'd5;
        cyc();
        idle();
        #1;
        chk("t2_woken", 32'(io.issue_valid_o), 32'h1);
        cyc();
        cyc();

        // wakeup coincident with dispatch
        disp(mk(6, 2, 7, 0, 1, 1));
        io.wake_valid_i = 1'b1;
        io.wake_tag_i   = 4'd7;
        cyc();
        idle();
        #1;
        chk("t3_bypass", 32'(io.issue_instr_o.src_a_rdy), 32'h1);
        cyc();
        cyc();

        // fill, refuse dispatch when full, then wrap pointers
        io.issue_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(mk(8 + i, i, 1, 1, 2, 1));
            cyc();
        end
        idle();
        #1;
        chk("full_ready", 32'(io.disp_ready_o), 32'h0);
        chk("full_count", 32'(io.count_o), 32'(DEPTH));
        disp(mk(15, 0, 1, 1, 2, 1));
        io.issue_ready_i = 1'b1;
        cyc();
        #1;
        chk("full_refuse", 32'(io.count_o), 32'(DEPTH - 1));
        for (int i = 0; i < 8; i++) begin
            disp(mk(i, i, 3, 1, 4, 1));
            cyc();
        end
        idle();
        repeat (DEPTH + 1) cyc();

        // non-ready head blocks a ready follower
        disp(mk(1, 0, 9, 0, 1, 1));
        cyc();
        disp(mk(2, 0, 1, 1, 1, 1));
        cyc();
        idle();
        cyc();
        cyc();
        io.wake_valid_i = 1'b1;
        io.wake_tag_i   = 4'd9;
        cyc();
        idle();
        repeat (3) cyc();

        // flush and then reset with three entries resident
        for (int pass = 0; pass < 2; pass++) begin
            io.issue_ready_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                disp(mk(5 + i, 0, 1, 1, 2, 1));
                cyc();
            end
            disp(mk(12, 0, 1, 1, 2, 1));
            io.issue_ready_i = 1'b1;
            if (pass == 0) begin
                io.flush_i = 1'b1;
            end else begin
                reset = 1'b1;
                #1;
                chk("reset_ready", 32'(io.disp_ready_o), 32'h0);
            end
            cyc();
            idle();
            #1;
            chk("drop_count", 32'(io.count_o), 32'h0);
            chk("drop_valid", 32'(io.issue_valid_o), 32'h0);
            cyc();
        end

        // random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            io.disp_valid_i  = ($urandom_range(0, 2) != 0);
            io.disp_instr_i  = mk($urandom_range(0, 15), $urandom_range(0, 15),
                                  $urandom_range(0, 7), $urandom_range(0, 1),
                                  $urandom_range(0, 7), $urandom_range(0, 1));
            io.wake_valid_i  = ($urandom_range(0, 1) != 0);
            io.wake_tag_i    = 4'($urandom_range(0, 7));
            io.issue_ready_i = ($urandom_range(0, 3) != 0);
            io.flush_i       = ($urandom_range(0, 49) == 0);
            reset            = ($urandom_range(0, 79) == 0);
            cyc();
        end
        idle();
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
